// File: rtl/hub75e_pkg.sv
// Shared constants, pixel types and write-FSM state encoding for the HUB75E
// ping-pong frame buffer.
package hub75e_pkg;

  localparam int unsigned ROW_BITS = 5;
  localparam int unsigned COL_BITS = 6;
  localparam int unsigned PIX_W    = 15;
  localparam int unsigned ADDR_W   = ROW_BITS + COL_BITS;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t upper;
    pix_t lower;
  } pix_pair_t;

  typedef enum logic [1:0] {
    WrIdle,
    WrFill,
    WrWait
  } wr_state_t;

endpackage

// File: rtl/fbuf_dpram.sv
// Simple 1W1R synchronous RAM; output register has a synchronous clear so the
// read port comes out of reset at zero while contents are left untouched.
module fbuf_dpram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 30
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [Depth];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hub75e_fbuf.sv
// Ping-pong frame buffer: renderer fills the back bank in raster order, the scan
// driver reads the front bank, and banks swap only at a scan frame boundary.
module hub75e_fbuf
  import hub75e_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic                 i_wr_sof,
  input  logic [2*PIX_W-1:0]   i_wr_data,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [2*PIX_W-1:0]   o_rd_data,
  input  logic                 i_scan_frame_done,
  output logic                 o_front_bank,
  output logic                 o_swap_pending,
  output logic                 o_sof_err,
  output logic [7:0]           o_swap_count
);

  localparam int unsigned DataW = 2 * PIX_W;

  wr_state_t         r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_front_bank;
  logic              r_swap_pending;
  logic              r_wr_ready;
  logic              r_sof_err;
  logic [7:0]        r_swap_count;

  logic              w_accept;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;

  assign w_accept = i_wr_valid & r_wr_ready;
  assign w_waddr  = i_wr_sof ? '0 : r_wr_ptr;

  // In idle only a start-of-frame word is stored; everything else is dropped.
  always_comb begin
    w_we = 1'b0;
    if (i_resetn && w_accept) begin
      w_we = (r_state == WrFill) || i_wr_sof;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state        <= WrIdle;
      r_wr_ptr       <= '0;
      r_front_bank   <= 1'b0;
      r_swap_pending <= 1'b0;
      r_wr_ready     <= 1'b0;
      r_sof_err      <= 1'b0;
      r_swap_count   <= '0;
    end else begin
      r_sof_err  <= 1'b0;
      r_wr_ready <= ~r_swap_pending;
      unique case (r_state)
        WrIdle: begin
          if (w_accept && i_wr_sof) begin
            r_wr_ptr <= ADDR_W'(1);
            r_state  <= WrFill;
          end
        end
        WrFill: begin
          if (w_accept) begin
            if (i_wr_sof) begin
              r_wr_ptr  <= ADDR_W'(1);
              r_sof_err <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              if (&r_wr_ptr) begin
                r_swap_pending <= 1'b1;
                r_wr_ready     <= 1'b0;
                r_state        <= WrWait;
              end
            end
          end
        end
        WrWait: begin
          if (i_scan_frame_done) begin
            r_front_bank   <= ~r_front_bank;
            r_swap_pending <= 1'b0;
            r_wr_ready     <= 1'b1;
            r_swap_count   <= r_swap_count + 1'b1;
            r_state        <= WrIdle;
          end
        end
        default: r_state <= WrIdle;
      endcase
    end
  end

  fbuf_dpram #(
    .ADDR_W (ADDR_W + 1),
    .DATA_W (DataW)
  ) u_ram (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_we     (w_we),
    .i_waddr  ({~r_front_bank, w_waddr}),
    .i_wdata  (i_wr_data),
    .i_raddr  ({r_front_bank, i_rd_addr}),
    .o_rdata  (o_rd_data)
  );

  assign o_wr_ready     = r_wr_ready;
  assign o_front_bank   = r_front_bank;
  assign o_swap_pending = r_swap_pending;
  assign o_sof_err      = r_sof_err;
  assign o_swap_count   = r_swap_count;

endmodule

// File: tb/tb_hub75e_fbuf.sv
// Self-checking bench for hub75e_fbuf: a reference bank model feeds a queue of
// expected read words that are popped when the 1-cycle read data appears.
module tb_hub75e_fbuf;

  localparam int AW = 11;
  localparam int DW = 30;
  localparam int NW = 2048;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_sof = 1'b0;
  logic          sfd = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          front_bank;
  logic          swap_pending;
  logic          sof_err;
  logic [7:0]    swap_count;

  logic [DW-1:0] model [2][NW];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_w;
  logic          exp_front = 1'b0;
  logic [7:0]    exp_count = '0;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  hub75e_fbuf u_dut (
    .i_clk             (clk),
    .i_resetn          (resetn),
    .i_wr_valid        (wr_valid),
    .o_wr_ready        (wr_ready),
    .i_wr_sof          (wr_sof),
    .i_wr_data         (wr_data),
    .i_rd_addr         (rd_addr),
    .o_rd_data         (rd_data),
    .i_scan_frame_done (sfd),
    .o_front_bank      (front_bank),
    .o_swap_pending    (swap_pending),
    .o_sof_err         (sof_err),
    .o_swap_count      (swap_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic sof, input logic done);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_sof   = sof;
    sfd      = done;
    tick();
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    sfd      = 1'b0;
  endtask

  task automatic pulse_sfd();
    sfd = 1'b1;
    tick();
    sfd = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", wr_ready); end
    n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rd_data); end
    n_cmp++; if (front_bank !== 1'b0) begin n_err++; $display("FAIL rst_front: got %b want 0", front_bank); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b want 0", swap_pending); end
    n_cmp++; if (sof_err !== 1'b0) begin n_err++; $display("FAIL rst_soferr: got %b want 0", sof_err); end
    n_cmp++; if (swap_count !== 8'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", swap_count); end
  endtask

  task automatic test_fill();
    int bad = 0;
    resetn = 1'b1;
    tick();
    for (int i = 0; i < NW; i++) begin
      if (wr_ready !== 1'b1) bad++;
      model[1][i] = DW'(i);
      send(DW'(i), i == 0, 1'b0);
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL fill_ready: got %0d stalls want 0", bad); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_end: got %b want 0", wr_ready); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL fill_pending: got %b want 1", swap_pending); end
    for (int i = 0; i < 3; i++) send(DW'(30'h3ABCDEF), 1'b1, 1'b0);
    n_cmp++; if (front_bank !== 1'b0) begin n_err++; $display("FAIL fill_front: got %b want 0", front_bank); end
    n_cmp++; if (wr_ready !== 1'b0 || swap_pending !== 1'b1) begin
      n_err++; $display("FAIL fill_hold: got ready %b pend %b want 0 1", wr_ready, swap_pending);
    end
  endtask

  task automatic test_swap();
    logic [AW-1:0] addrs [4] = '{11'h123, 11'h000, 11'h7FF, 11'h5A5};
    pulse_sfd();
    exp_front = 1'b1;
    exp_count = exp_count + 8'd1;
    n_cmp++; if (front_bank !== exp_front) begin n_err++; $display("FAIL swap_front: got %b want %b", front_bank, exp_front); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL swap_pending: got %b want 0", swap_pending); end
    n_cmp++; if (swap_count !== exp_count) begin n_err++; $display("FAIL swap_count: got %0d want %0d", swap_count, exp_count); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL swap_ready: got %b want 1", wr_ready); end
    for (int j = 0; j < 4; j++) begin
      rd_addr = addrs[j];
      exp_q.push_back(model[exp_front][addrs[j]]);
      tick();
      exp_w = exp_q.pop_front();
      n_cmp++; if (rd_data !== exp_w) begin n_err++; $display("FAIL swap_read[%0d]: got %h want %h", j, rd_data, exp_w); end
    end
  endtask

  task automatic test_sof_restart();
    int pulses = 0;
    logic pend_early;
    logic [AW-1:0] addrs [4] = '{11'h000, 11'h063, 11'h050, 11'h7FF};
    for (int i = 0; i < 99; i++) begin
      model[0][i] = DW'(32'h100000 + i);
      send(model[0][i], i == 0, 1'b0);
    end
    model[0][0] = DW'(32'h200000);
    send(model[0][0], 1'b1, 1'b0);
    n_cmp++; if (sof_err !== 1'b1) begin n_err++; $display("FAIL sof_err_pulse: got %b want 1", sof_err); end
    pend_early = 1'b0;
    for (int k = 1; k < NW; k++) begin
      model[0][k] = DW'(32'h200000 + k);
      send(model[0][k], 1'b0, 1'b0);
      if (sof_err === 1'b1) pulses++;
      if (k == NW - 2) pend_early = swap_pending;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL sof_err_extra: got %0d pulses want 0", pulses); end
    n_cmp++; if (pend_early !== 1'b0) begin n_err++; $display("FAIL sof_early: got %b want 0", pend_early); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL sof_done: got %b want 1", swap_pending); end
    pulse_sfd();
    exp_front = 1'b0;
    exp_count = exp_count + 8'd1;
    n_cmp++; if (front_bank !== exp_front) begin n_err++; $display("FAIL sof_front: got %b want %b", front_bank, exp_front); end
    for (int j = 0; j < 4; j++) begin
      rd_addr = addrs[j];
      exp_q.push_back(model[exp_front][addrs[j]]);
      tick();
      exp_w = exp_q.pop_front();
      n_cmp++; if (rd_data !== exp_w) begin n_err++; $display("FAIL sof_read[%0d]: got %h want %h", j, rd_data, exp_w); end
    end
  endtask

  task automatic test_same_cycle();
    logic [AW-1:0] a;
    for (int i = 0; i < NW; i++) begin
      model[1][i] = DW'($urandom);
      send(model[1][i], i == 0, i == NW - 1);
    end
    n_cmp++; if (front_bank !== exp_front) begin n_err++; $display("FAIL same_front: got %b want %b", front_bank, exp_front); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL same_pending: got %b want 1", swap_pending); end
    n_cmp++; if (swap_count !== exp_count) begin n_err++; $display("FAIL same_count: got %0d want %0d", swap_count, exp_count); end
    tick();
    tick();
    pulse_sfd();
    exp_front = 1'b1;
    exp_count = exp_count + 8'd1;
    n_cmp++; if (front_bank !== exp_front) begin n_err++; $display("FAIL same_swap: got %b want %b", front_bank, exp_front); end
    n_cmp++; if (swap_count !== exp_count) begin n_err++; $display("FAIL same_count2: got %0d want %0d", swap_count, exp_count); end
    pulse_sfd();
    n_cmp++; if (front_bank !== exp_front || swap_count !== exp_count) begin
      n_err++; $display("FAIL idle_sfd: got %b/%0d want %b/%0d", front_bank, swap_count, exp_front, exp_count);
    end
    for (int j = 0; j < 4; j++) begin
      a = AW'($urandom_range(0, NW - 1));
      rd_addr = a;
      exp_q.push_back(model[exp_front][a]);
      tick();
      exp_w = exp_q.pop_front();
      n_cmp++; if (rd_data !== exp_w) begin n_err++; $display("FAIL same_read[%0d]: got %h want %h", j, rd_data, exp_w); end
    end
  endtask

  task automatic test_no_sof();
    int pend = 0;
    int stall = 0;
    logic [AW-1:0] addrs [3] = '{11'h123, 11'h063, 11'h7FE};
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_front = 1'b0;
    exp_count = 8'd0;
    tick();
    for (int i = 0; i < NW + 52; i++) begin
      if (wr_ready !== 1'b1) stall++;
      send(DW'(32'h3FFFFFFF ^ i), 1'b0, 1'b0);
      if (swap_pending !== 1'b0) pend++;
    end
    n_cmp++; if (pend != 0) begin n_err++; $display("FAIL nosof_pending: got %0d cycles want 0", pend); end
    n_cmp++; if (stall != 0) begin n_err++; $display("FAIL nosof_ready: got %0d stalls want 0", stall); end
    for (int j = 0; j < 3; j++) begin
      rd_addr = addrs[j];
      exp_q.push_back(model[exp_front][addrs[j]]);
      tick();
      exp_w = exp_q.pop_front();
      n_cmp++; if (rd_data !== exp_w) begin n_err++; $display("FAIL nosof_read[%0d]: got %h want %h", j, rd_data, exp_w); end
    end
    pulse_sfd();
    n_cmp++; if (front_bank !== 1'b0 || swap_count !== 8'd0) begin
      n_err++; $display("FAIL nosof_sfd: got %b/%0d want 0/0", front_bank, swap_count);
    end
  endtask

  task automatic test_reset_mid();
    int pend = 0;
    logic [AW-1:0] addrs [3] = '{11'h000, 11'h1F4, 11'h7FF};
    for (int i = 0; i < 500; i++) begin
      model[1][i] = DW'(32'h3000000 + i);
      send(model[1][i], i == 0, 1'b0);
    end
    rd_addr = 11'h123;
    resetn  = 1'b0;
    send(DW'(32'h3000000 + 500), 1'b0, 1'b0);
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b want 0", wr_ready); end
    n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL mid_rdata: got %h want 0", rd_data); end
    n_cmp++; if (front_bank !== 1'b0 || swap_pending !== 1'b0 || sof_err !== 1'b0) begin
      n_err++; $display("FAIL mid_flags: got %b%b%b want 000", front_bank, swap_pending, sof_err);
    end
    n_cmp++; if (swap_count !== 8'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", swap_count); end
    resetn = 1'b1;
    tick();
    for (int i = 0; i < NW; i++) begin
      send(DW'(i), 1'b0, 1'b0);
      if (swap_pending !== 1'b0) pend++;
    end
    n_cmp++; if (pend != 0) begin n_err++; $display("FAIL mid_nosof: got %0d cycles want 0", pend); end
    for (int i = 0; i < NW; i++) begin
      model[1][i] = DW'($urandom);
      send(model[1][i], i == 0, 1'b0);
    end
    n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL mid_refill: got %b want 1", swap_pending); end
    pulse_sfd();
    exp_front = 1'b1;
    exp_count = 8'd1;
    n_cmp++; if (front_bank !== exp_front || swap_count !== exp_count) begin
      n_err++; $display("FAIL mid_swap: got %b/%0d want %b/%0d", front_bank, swap_count, exp_front, exp_count);
    end
    for (int j = 0; j < 3; j++) begin
      rd_addr = addrs[j];
      exp_q.push_back(model[exp_front][addrs[j]]);
      tick();
      exp_w = exp_q.pop_front();
      n_cmp++; if (rd_data !== exp_w) begin n_err++; $display("FAIL mid_read[%0d]: got %h want %h", j, rd_data, exp_w); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_swap();
    test_sof_restart();
    test_same_cycle();
    test_no_sof();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hub75e_fbuf.md
Name: hub75e_fbuf

Overview:
- Double-buffered (ping-pong) frame buffer feeding the HUB75E scan driver; replaces the fixed logo ROM as the pixel source.
- Upstream renderer streams pixel-pair words in raster order over a valid/ready handshake into the back bank.
- Scan driver reads the front bank by address with 1-cycle latency.
- Banks swap only at a scan frame boundary, so a partially written frame is never displayed.

Parameters:
- ROW_BITS, 5, row-address bits (32 row pairs, upper/lower half panel).
- COL_BITS, 6, column-address bits (64 columns).
- PIX_W, 15, bits per pixel (R5:G5:B5, R in MSBs).
- ADDR_W, ROW_BITS+COL_BITS, derived word-address width; frame = 2^ADDR_W words.

Ports:
- clk  in  1  single clock; scan driver's clock domain.
- resetn  in  1  synchronous, active-low reset.
- wr_valid  in  1  upstream word valid.
- wr_ready  out  1  buffer accepts word this cycle.
- wr_sof  in  1  qualifies current word as first of frame (address 0).
- wr_data  in  2*PIX_W  {upper-half pixel, lower-half pixel}.
- rd_addr  in  ADDR_W  scan read address {row, col}.
- rd_data  out  2*PIX_W  front-bank word, 1 cycle after rd_addr.
- scan_frame_done  in  1  1-cycle pulse when scan finishes the last row.
- front_bank  out  1  bank currently displayed.
- swap_pending  out  1  back bank complete, awaiting swap.
- sof_err  out  1  1-cycle pulse: wr_sof arrived mid-frame.
- swap_count  out  8  swaps performed, wraps 255->0.

Behaviour:
- Storage: 2 x 2^ADDR_W words of 2*PIX_W bits. Physical address = {bank, word_addr}. Write bank = ~front_bank.
- Reset (resetn=0 at clk edge):
  - wr_ready=0, rd_data=0, front_bank=0, swap_pending=0, sof_err=0, swap_count=0, wr_ptr=0.
  - RAM contents are not cleared.
- A word is accepted when wr_valid & wr_ready on a rising edge.
- wr_ready = ~swap_pending (registered, deasserted during reset). Backpressure lasts from frame completion until the swap.
- Write FSM, states WR_IDLE, WR_FILL, WR_WAIT:
  - WR_IDLE: accepted words without wr_sof are discarded, not written. An accepted word with wr_sof is written at address 0; wr_ptr<=1; go to WR_FILL.
  - WR_FILL: each accepted word is written at wr_ptr; wr_ptr increments.
    - Accepted word with wr_sof: write at 0, wr_ptr<=1, pulse sof_err next cycle, stay in WR_FILL.
    - Accepting the word at address 2^ADDR_W-1: wr_ptr wraps to 0, swap_pending<=1, go to WR_WAIT.
  - WR_WAIT: wr_ready=0. On scan_frame_done: front_bank<=~front_bank, swap_pending<=0, swap_count+=1, go to WR_IDLE.
- Same-cycle event rules:
  - Last word accepted in the same cycle as scan_frame_done: no swap that cycle. Swap occurs on the next scan_frame_done.
  - scan_frame_done while not in WR_WAIT is ignored; front bank stays, swap_count unchanged.
- Read path: rd_data <= RAM[{front_bank, rd_addr}] on every edge. Latency is exactly 1 cycle.
  - On the swap edge, the read uses the old front_bank. The next read uses the new one.
- Read and write never collide because the banks are disjoint. No read-during-write handling is needed.
- resetn low mid-frame: everything returns to its reset values. A partial back-bank frame is abandoned, and the writer must restart with wr_sof.
- All counters are unsigned with natural modular wrap. ADDR_W-bit wr_ptr needs no explicit compare beyond all-ones detection.

Decomposition:
- Shared package hub75e_pkg, containing:
  - ROW_BITS, COL_BITS, PIX_W, ADDR_W constants.
  - typedef pix_t (PIX_W bits) and pix_pair_t {pix_t upper; pix_t lower}.
  - Write-FSM state enum wr_state_t.
- Shared with hub75e_if and the threshold/compare logic.
- One sub-module: fbuf_dpram, a simple 1W1R synchronous RAM (depth 2^(ADDR_W+1)) that infers block RAM. The control FSM, pointer and bank logic stay in hub75e_fbuf.

Test Plan:
1. Reset, then stream 2048 words data=addr with wr_sof on word 0, wr_valid=1 throughout. Required: wr_ready=1 for 2048 cycles then 0; swap_pending=1; front_bank stays 0.
2. From state 1, pulse scan_frame_done. Required: next cycle front_bank=1, swap_pending=0, swap_count=1, wr_ready=1. rd_addr=0x123 returns 0x123 one cycle later.
3. Send wr_sof on the 100th word of a frame. Required: sof_err pulses once; that word is written at address 0. The frame then completes after 2047 further words (2048 counted from the restart).
4. Accept the last word in the same cycle as scan_frame_done. Required: front_bank unchanged, swap_pending=1. The swap happens only on the following scan_frame_done pulse.
5. Stream words without wr_sof after reset. Required: nothing is written and swap_pending stays 0. Scan reads continue from bank 0 unaffected.
6. Assert resetn=0 for 1 cycle at word 500 of a fill. Required: all outputs return to reset values; swap_count=0; the next frame requires wr_sof.
